// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : shared widths, ALU opcodes and the operand forwarding helper
// Revision: 1.0
// ============================================================================
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int PC_W   = 12;
  localparam int RA_W   = 3;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADC  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SBC  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_SUBI = 4'h9;
  localparam logic [3:0] OP_ANDI = 4'hA;
  localparam logic [3:0] OP_ORI  = 4'hB;
  localparam logic [3:0] OP_SHL  = 4'hC;
  localparam logic [3:0] OP_SHR  = 4'hD;
  localparam logic [3:0] OP_BZ   = 4'hE;
  localparam logic [3:0] OP_BC   = 4'hF;

  function automatic logic is_imm_op(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

  // A pending load in EXE/MEM has no data yet, so it must not forward.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [RA_W-1:0]   src,
    input logic [DATA_W-1:0] reg_data,
    input logic              exm_reg_wr,
    input logic              exm_mem_rd,
    input logic [RA_W-1:0]   exm_rd,
    input logic [DATA_W-1:0] exm_res,
    input logic              wb_reg_wr,
    input logic [RA_W-1:0]   wb_rd,
    input logic [DATA_W-1:0] wb_data
  );
    if (exm_reg_wr && !exm_mem_rd && (exm_rd == src))
      return exm_res;
    else if (wb_reg_wr && (wb_rd == src))
      return wb_data;
    else
      return reg_data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exe_stage_if.sv
`default_nettype none
// ============================================================================
// exe_stage_if : ID/EXE fields, write-back bypass and EXE/MEM results
// Revision: 1.0
// ============================================================================
interface exe_stage_if;
  import cpu_pkg::*;

  logic              stall_IN;
  logic              regWr_IN;
  logic              memRd_IN;
  logic              memWr_IN;
  logic              cWr_IN;
  logic              zWr_IN;
  logic [3:0]        aluOp_IN;
  logic [RA_W-1:0]   rd_IN;
  logic [RA_W-1:0]   rs_IN;
  logic [RA_W-1:0]   rt_IN;
  logic [DATA_W-1:0] regData1_IN;
  logic [DATA_W-1:0] regData2_IN;
  logic [DATA_W-1:0] immConst_IN;
  logic [DATA_W-1:0] brDisp_IN;
  logic [PC_W-1:0]   pcPlus1_IN;
  logic              wbRegWr_IN;
  logic [RA_W-1:0]   wbRd_IN;
  logic [DATA_W-1:0] wbData_IN;

  logic              regWr_OUT;
  logic              memRd_OUT;
  logic              memWr_OUT;
  logic [RA_W-1:0]   rd_OUT;
  logic [DATA_W-1:0] aluResult_OUT;
  logic [DATA_W-1:0] storeData_OUT;
  logic              cFlag_OUT;
  logic              zFlag_OUT;
  logic              brTaken_OUT;
  logic [PC_W-1:0]   brTarget_OUT;

  modport slave (
    input  stall_IN, regWr_IN, memRd_IN, memWr_IN, cWr_IN, zWr_IN, aluOp_IN,
           rd_IN, rs_IN, rt_IN, regData1_IN, regData2_IN, immConst_IN,
           brDisp_IN, pcPlus1_IN, wbRegWr_IN, wbRd_IN, wbData_IN,
    output regWr_OUT, memRd_OUT, memWr_OUT, rd_OUT, aluResult_OUT,
           storeData_OUT, cFlag_OUT, zFlag_OUT, brTaken_OUT, brTarget_OUT
  );

  modport master (
    output stall_IN, regWr_IN, memRd_IN, memWr_IN, cWr_IN, zWr_IN, aluOp_IN,
           rd_IN, rs_IN, rt_IN, regData1_IN, regData2_IN, immConst_IN,
           brDisp_IN, pcPlus1_IN, wbRegWr_IN, wbRd_IN, wbData_IN,
    input  regWr_OUT, memRd_OUT, memWr_OUT, rd_OUT, aluResult_OUT,
           storeData_OUT, cFlag_OUT, zFlag_OUT, brTaken_OUT, brTarget_OUT
  );

endinterface
`default_nettype wire

// File: rtl/alu8.sv
`default_nettype none
// ============================================================================
// alu8 : combinational 8-bit ALU with carry/borrow out
// Revision: 1.0
// ============================================================================
module alu8
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] res,
  output logic              cout
);

  localparam logic [DATA_W:0] c_zero9 = '0;

  logic [DATA_W:0] w_cin9;
  logic [DATA_W:0] w_sum;

  assign w_cin9 = {{DATA_W{1'b0}}, cin};

  // Bit 8 of the 9-bit difference is the borrow for subtraction.
  always_comb begin
    w_sum = c_zero9;
    res   = '0;
    cout  = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: begin
        w_sum = {1'b0, a} + {1'b0, b};
        {cout, res} = w_sum;
      end
      OP_ADC: begin
        w_sum = {1'b0, a} + {1'b0, b} + w_cin9;
        {cout, res} = w_sum;
      end
      OP_SUB, OP_SUBI: begin
        w_sum = {1'b0, a} - {1'b0, b};
        {cout, res} = w_sum;
      end
      OP_SBC: begin
        w_sum = {1'b0, a} - {1'b0, b} - w_cin9;
        {cout, res} = w_sum;
      end
      OP_AND, OP_ANDI: res = a & b;
      OP_OR,  OP_ORI:  res = a | b;
      OP_XOR:          res = a ^ b;
      OP_MOV:          res = b;
      OP_SHL: begin
        res  = {a[DATA_W-2:0], 1'b0};
        cout = a[DATA_W-1];
      end
      OP_SHR: begin
        res  = {1'b0, a[DATA_W-1:1]};
        cout = a[0];
      end
      default: res = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/exe_stage.sv
`default_nettype none
// ============================================================================
// exe_stage : forwarding, ALU, C/Z flags, branch resolve and EXE/MEM register
// Revision: 1.0
// ============================================================================
module exe_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  exe_stage_if.slave  bus
);

  logic              reg_wr_q,   reg_wr_d;
  logic              mem_rd_q,   mem_rd_d;
  logic              mem_wr_q,   mem_wr_d;
  logic [RA_W-1:0]   rd_q,       rd_d;
  logic [DATA_W-1:0] alu_res_q,  alu_res_d;
  logic [DATA_W-1:0] st_data_q,  st_data_d;
  logic              c_q,        c_d;
  logic              z_q,        z_d;

  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;
  logic [DATA_W-1:0] w_op_b;
  logic [DATA_W-1:0] w_res;
  logic              w_cout;

  // Sources compare against the held EXE/MEM contents, also while stalled.
  always_comb begin
    w_fwd_rs = fwd_sel(bus.rs_IN, bus.regData1_IN, reg_wr_q, mem_rd_q, rd_q,
                       alu_res_q, bus.wbRegWr_IN, bus.wbRd_IN, bus.wbData_IN);
    w_fwd_rt = fwd_sel(bus.rt_IN, bus.regData2_IN, reg_wr_q, mem_rd_q, rd_q,
                       alu_res_q, bus.wbRegWr_IN, bus.wbRd_IN, bus.wbData_IN);
    w_op_b   = is_imm_op(bus.aluOp_IN) ? bus.immConst_IN : w_fwd_rt;
  end

  alu8 u_alu (
    .a    (w_fwd_rs),
    .b    (w_op_b),
    .cin  (c_q),
    .op   (bus.aluOp_IN),
    .res  (w_res),
    .cout (w_cout)
  );

  always_comb begin
    reg_wr_d  = reg_wr_q;
    mem_rd_d  = mem_rd_q;
    mem_wr_d  = mem_wr_q;
    rd_d      = rd_q;
    alu_res_d = alu_res_q;
    st_data_d = st_data_q;
    c_d       = c_q;
    z_d       = z_q;
    if (!bus.stall_IN) begin
      reg_wr_d  = bus.regWr_IN;
      mem_rd_d  = bus.memRd_IN;
      mem_wr_d  = bus.memWr_IN;
      rd_d      = bus.rd_IN;
      alu_res_d = w_res;
      st_data_d = w_fwd_rt;
      if (bus.cWr_IN) c_d = w_cout;
      if (bus.zWr_IN) z_d = (w_res == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_wr_q  <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      rd_q      <= '0;
      alu_res_q <= '0;
      st_data_q <= '0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
    end else begin
      reg_wr_q  <= reg_wr_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      rd_q      <= rd_d;
      alu_res_q <= alu_res_d;
      st_data_q <= st_data_d;
      c_q       <= c_d;
      z_q       <= z_d;
    end
  end

  assign bus.regWr_OUT     = reg_wr_q;
  assign bus.memRd_OUT     = mem_rd_q;
  assign bus.memWr_OUT     = mem_wr_q;
  assign bus.rd_OUT        = rd_q;
  assign bus.aluResult_OUT = alu_res_q;
  assign bus.storeData_OUT = st_data_q;
  assign bus.cFlag_OUT     = c_q;
  assign bus.zFlag_OUT     = z_q;

  // Branch uses the flag registers, so a flag write one slot ahead is visible.
  assign bus.brTaken_OUT  = ((bus.aluOp_IN == OP_BZ) && z_q) ||
                            ((bus.aluOp_IN == OP_BC) && c_q);
  assign bus.brTarget_OUT = bus.pcPlus1_IN +
                            {{(PC_W-DATA_W){bus.brDisp_IN[DATA_W-1]}}, bus.brDisp_IN};

endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// ============================================================================
// tb_exe_stage : directed and random stimulus against a behavioural model
// Revision: 1.0
// ============================================================================
module tb_exe_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  exe_stage_if bus();

  exe_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int m_reg_wr, m_mem_rd, m_mem_wr, m_rd, m_res, m_st, m_c, m_z;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_alu(input int op, input int a, input int b,
                                 input int cin, output int cn);
    int s;
    cn = 0;
    case (op)
      0, 8:   begin s = a + b;       cn = (s > 255) ? 1 : 0; end
      1:      begin s = a + b + cin; cn = (s > 255) ? 1 : 0; end
      2, 9:   begin s = a - b;       cn = (s < 0) ? 1 : 0;   end
      3:      begin s = a - b - cin; cn = (s < 0) ? 1 : 0;   end
      4, 10:  s = a & b;
      5, 11:  s = a | b;
      6:      s = a ^ b;
      7:      s = b;
      12:     begin s = a * 2; cn = a / 128; end
      13:     begin s = a / 2; cn = a % 2;   end
      default: s = 0;
    endcase
    return s & 255;
  endfunction

  function automatic int ref_src(input int src, input int rdata);
    if (m_reg_wr != 0 && m_mem_rd == 0 && m_rd == src) return m_res;
    if (bus.wbRegWr_IN && int'(bus.wbRd_IN) == src)  return int'(bus.wbData_IN);
    return rdata;
  endfunction

  function automatic int ref_taken();
    return ((bus.aluOp_IN == 4'hE && m_z != 0) || (bus.aluOp_IN == 4'hF && m_c != 0)) ? 1 : 0;
  endfunction

  function automatic int ref_target();
    int d;
    d = int'(bus.brDisp_IN);
    if (d >= 128) d = d - 256;
    return (int'(bus.pcPlus1_IN) + d) & 'hFFF;
  endfunction

  // Called right after each rising edge, before any input changes.
  task automatic model_step();
    int a, rt, b, res, cn;
    if (!rst) begin
      m_reg_wr = 0; m_mem_rd = 0; m_mem_wr = 0; m_rd = 0;
      m_res = 0; m_st = 0; m_c = 0; m_z = 0;
    end else if (!bus.stall_IN) begin
      a   = ref_src(int'(bus.rs_IN), int'(bus.regData1_IN));
      rt  = ref_src(int'(bus.rt_IN), int'(bus.regData2_IN));
      b   = (bus.aluOp_IN >= 8 && bus.aluOp_IN <= 11) ? int'(bus.immConst_IN) : rt;
      res = ref_alu(int'(bus.aluOp_IN), a, b, m_c, cn);
      if (bus.cWr_IN) m_c = cn;
      if (bus.zWr_IN) m_z = (res == 0) ? 1 : 0;
      m_reg_wr = int'(bus.regWr_IN);
      m_mem_rd = int'(bus.memRd_IN);
      m_mem_wr = int'(bus.memWr_IN);
      m_rd     = int'(bus.rd_IN);
      m_res    = res;
      m_st     = rt;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("regWr",     int'(bus.regWr_OUT),     m_reg_wr);
      check("memRd",     int'(bus.memRd_OUT),     m_mem_rd);
      check("memWr",     int'(bus.memWr_OUT),     m_mem_wr);
      check("rd",        int'(bus.rd_OUT),        m_rd);
      check("aluResult", int'(bus.aluResult_OUT), m_res);
      check("storeData", int'(bus.storeData_OUT), m_st);
      check("cFlag",     int'(bus.cFlag_OUT),     m_c);
      check("zFlag",     int'(bus.zFlag_OUT),     m_z);
      check("brTaken",   int'(bus.brTaken_OUT),   ref_taken());
      check("brTarget",  int'(bus.brTarget_OUT),  ref_target());
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic rand_in();
    bus.stall_IN    = ($urandom_range(0, 4) == 0);
    bus.regWr_IN    = 1'($urandom);
    bus.memRd_IN    = 1'($urandom);
    bus.memWr_IN    = 1'($urandom);
    bus.cWr_IN      = 1'($urandom);
    bus.zWr_IN      = 1'($urandom);
    bus.aluOp_IN    = 4'($urandom);
    bus.rd_IN       = 3'($urandom);
    bus.rs_IN       = 3'($urandom);
    bus.rt_IN       = 3'($urandom);
    bus.regData1_IN = 8'($urandom);
    bus.regData2_IN = 8'($urandom);
    bus.immConst_IN = 8'($urandom);
    bus.brDisp_IN   = 8'($urandom);
    bus.pcPlus1_IN  = 12'($urandom);
    bus.wbRegWr_IN  = 1'($urandom);
    bus.wbRd_IN     = 3'($urandom);
    bus.wbData_IN   = 8'($urandom);
  endtask

  task automatic set_op(input int op, input int rs, input int rt, input int rd,
                        input int d1, input int d2, input int imm,
                        input bit rw, input bit cw, input bit zw);
    bus.stall_IN    = 1'b0;
    bus.memRd_IN    = 1'b0;
    bus.memWr_IN    = 1'b0;
    bus.brDisp_IN   = '0;
    bus.pcPlus1_IN  = '0;
    bus.wbRegWr_IN  = 1'b0;
    bus.wbRd_IN     = '0;
    bus.wbData_IN   = '0;
    bus.aluOp_IN    = 4'(op);
    bus.rs_IN       = 3'(rs);
    bus.rt_IN       = 3'(rt);
    bus.rd_IN       = 3'(rd);
    bus.regData1_IN = 8'(d1);
    bus.regData2_IN = 8'(d2);
    bus.immConst_IN = 8'(imm);
    bus.regWr_IN    = rw;
    bus.cWr_IN      = cw;
    bus.zWr_IN      = zw;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held two cycles with random inputs
    rst = 1'b0;
    rand_in();
    tick();
    chk_en = 1'b1;
    rand_in();
    tick();
    check("rst_res", int'(bus.aluResult_OUT), 0);
    check("rst_c",   int'(bus.cFlag_OUT),     0);
    check("rst_z",   int'(bus.zFlag_OUT),     0);
    check("rst_rw",  int'(bus.regWr_OUT),     0);

    rst = 1'b1;
    set_op(0, 1, 2, 7, 'hF0, 'h20, 0, 1, 1, 1);
    tick();
    check("add_res", int'(bus.aluResult_OUT), 'h10);
    check("add_c",   int'(bus.cFlag_OUT),     1);
    check("add_z",   int'(bus.zFlag_OUT),     0);
    set_op(1, 1, 2, 7, 'h01, 'h01, 0, 1, 1, 1);
    tick();
    check("adc_res", int'(bus.aluResult_OUT), 'h03);

    // Forwarding priority: EXE/MEM over WB, unless EXE/MEM is a load
    set_op(7, 5, 5, 2, 0, 'h55, 0, 1, 0, 0);
    tick();
    set_op(0, 2, 4, 6, 'h11, 0, 0, 0, 0, 0);
    bus.wbRegWr_IN = 1'b1; bus.wbRd_IN = 3'd2; bus.wbData_IN = 8'hAA;
    tick();
    check("fwd_exmem", int'(bus.aluResult_OUT), 'h55);
    set_op(8, 1, 3, 2, 0, 0, 'h30, 1, 0, 0);
    bus.memRd_IN = 1'b1;
    tick();
    check("ld_addr", int'(bus.aluResult_OUT), 'h30);
    set_op(0, 2, 4, 6, 'h11, 0, 0, 0, 0, 0);
    bus.wbRegWr_IN = 1'b1; bus.wbRd_IN = 3'd2; bus.wbData_IN = 8'hAA;
    tick();
    check("fwd_wb", int'(bus.aluResult_OUT), 'hAA);

    // SUB sets Z, BZ right behind it sees it
    set_op(2, 1, 3, 7, 'h37, 'h37, 0, 0, 1, 1);
    tick();
    check("sub_z", int'(bus.zFlag_OUT), 1);
    set_op(14, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.pcPlus1_IN = 12'h010; bus.brDisp_IN = 8'hFC;
    #1;
    check("bz_taken",  int'(bus.brTaken_OUT),  1);
    check("bz_target", int'(bus.brTarget_OUT), 'h00C);
    tick();
    set_op(0, 1, 2, 7, 1, 1, 0, 0, 0, 1);
    tick();
    set_op(14, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.pcPlus1_IN = 12'h010; bus.brDisp_IN = 8'hFC;
    #1;
    check("bz_not_taken", int'(bus.brTaken_OUT), 0);
    tick();

    // Stall holds outputs and flags
    set_op(0, 1, 2, 7, 'hF0, 'h20, 0, 1, 1, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_op(2, 1, 2, 3, int'($urandom_range(0, 255)), 1, 0, 1, 1, 1);
      bus.stall_IN = 1'b1;
      tick();
      check("stall_res", int'(bus.aluResult_OUT), 'h10);
      check("stall_c",   int'(bus.cFlag_OUT),     1);
      check("stall_rd",  int'(bus.rd_OUT),        7);
    end
    set_op(2, 1, 2, 3, 5, 1, 0, 1, 1, 1);
    tick();
    check("unstall_res", int'(bus.aluResult_OUT), 'h04);
    check("unstall_c",   int'(bus.cFlag_OUT),     0);

    // Shifts and borrow
    set_op(13, 1, 2, 7, 'h81, 0, 0, 1, 1, 1);
    tick();
    check("shr_res", int'(bus.aluResult_OUT), 'h40);
    check("shr_c",   int'(bus.cFlag_OUT),     1);
    set_op(12, 1, 2, 7, 'h81, 0, 0, 1, 1, 1);
    tick();
    check("shl_res", int'(bus.aluResult_OUT), 'h02);
    check("shl_c",   int'(bus.cFlag_OUT),     1);
    set_op(2, 1, 2, 7, 'h00, 'h01, 0, 1, 1, 1);
    tick();
    check("borrow_res", int'(bus.aluResult_OUT), 'hFF);
    check("borrow_c",   int'(bus.cFlag_OUT),     1);

    // Random traffic with occasional reset pulses
    for (int i = 0; i < 2000; i++) begin
      rand_in();
      rst = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage; consumes every field registered by the ID/EXE pipeline register.
- Resolves operands through a forwarding network, runs the 8-bit ALU, and holds the architectural carry (C) and zero (Z) flags.
- Resolves conditional branches and captures results in an internal EXE/MEM register that feeds the memory stage.

Parameters:
- DATA_W, 8, datapath/register width
- PC_W, 12, program counter width
- RA_W, 3, register-file address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- stall_IN  in  1  memory stage busy; hold all state
- regWr_IN, memRd_IN, memWr_IN, cWr_IN, zWr_IN  in  1 each  control from ID/EXE
- aluOp_IN  in  4  operation code
- rd_IN, rs_IN, rt_IN  in  RA_W  destination/source register numbers
- regData1_IN, regData2_IN, immConst_IN, brDisp_IN  in  DATA_W  rs data, rt data, immediate, branch displacement
- pcPlus1_IN  in  PC_W  address of next instruction
- wbRegWr_IN  in  1  MEM/WB writes register
- wbRd_IN  in  RA_W  MEM/WB destination
- wbData_IN  in  DATA_W  MEM/WB write-back value
- regWr_OUT, memRd_OUT, memWr_OUT  out  1  registered EXE/MEM control
- rd_OUT  out  RA_W  registered destination
- aluResult_OUT  out  DATA_W  registered ALU result / memory address
- storeData_OUT  out  DATA_W  registered forwarded rt value
- cFlag_OUT, zFlag_OUT  out  1  current flag registers
- brTaken_OUT  out  1  combinational branch-taken indication
- brTarget_OUT  out  PC_W  combinational branch target

Behaviour:
- Reset, when rst==0 at posedge: all EXE/MEM outputs 0; C=0; Z=0. Reset overrides stall_IN.
- Forwarding for rs and for rt, each independently, in priority order:
  - Use aluResult_OUT when regWr_OUT && !memRd_OUT && rd_OUT==src.
  - Otherwise use wbData_IN when wbRegWr_IN && wbRd_IN==src.
  - Otherwise use regDataN_IN.
  - Register 0 gets no special treatment.
- Load-use hazards are not detected here; the hazard unit stalls upstream.
- A = fwd rs. B = fwd rt, except for ops 8..B, where B = immConst_IN.
- aluOp encoding:
  - 0 ADD; 1 ADC (A+B+C); 2 SUB; 3 SBC (A-B-C)
  - 4 AND; 5 OR; 6 XOR; 7 MOV (res=B)
  - 8 ADDI; 9 SUBI; A ANDI; B ORI
  - C SHL (res=A<<1, cnew=A[7]); D SHR (res=A>>1, cnew=A[0])
  - E BZ; F BC
- Arithmetic is 9-bit: cnew = bit 8 of the sum, or the borrow (1 = borrow) for subtraction. Logic/MOV give cnew=0. Znew = (res==0).
- Loads/stores: the decoder issues ADDI; aluResult is the address.
- Flags: at posedge, if rst==1 && !stall_IN, then C<=cnew if cWr_IN, and Z<=Znew if zWr_IN.
- BZ/BC write res=0 to the pipeline. The decoder clears regWr/cWr/zWr for them.
- Branch, combinational, in the same cycle:
  - brTaken_OUT = (op==E && Z) || (op==F && C), using the flag register values.
  - A flag-setting instruction directly ahead is therefore seen, since it wrote at the preceding edge.
  - brTarget_OUT = pcPlus1_IN + sign-extended brDisp_IN, modulo 2^PC_W.
  - The flush of IF/ID is done upstream; this block does not squash itself.
- EXE/MEM register: at posedge, if !stall_IN, capture regWr, memRd, memWr, rd, res and fwd rt. If stall_IN, hold all outputs and flags unchanged.
- Forwarding compares against the held outputs during a stall.
- Latency: one cycle from inputs to EXE/MEM outputs; flags visible one cycle after the write.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W/PC_W/RA_W
  - aluOp localparams (OP_ADD..OP_BC)
- One sub-module, alu8: purely combinational.
  - Inputs: a, b, cin, op.
  - Outputs: res, cout.
- Forwarding, flags, branch logic and the pipeline register stay in exe_stage.

Test Plan:
- Reset: hold rst=0 two cycles with random inputs -> all outputs 0, C=Z=0. Release -> first capture on the next edge.
- ADD with carry: A=0xF0, B=0x20, op=0, cWr=zWr=1 -> aluResult_OUT=0x10, C=1, Z=0. Next ADC A=0x01, B=0x01 -> 0x03.
- Forwarding priority: EXE/MEM holds rd=2, res=0x55. WB has rd=2, data=0xAA. Issue rs=2 ADD with B=0 -> 0x55. With EXE/MEM memRd=1 -> 0xAA.
- SUB then BZ back-to-back: A=B=0x37, zWr=1. Then BZ with pcPlus1=0x010, brDisp=0xFC -> brTaken=1, brTarget=0x00C. With Z=0 -> brTaken=0.
- Stall: stall_IN=1 for 3 cycles while inputs change, cWr=1 -> outputs and C unchanged. Release -> capture the current inputs.
- SHR/SHL: A=0x81 SHR, cWr=1 -> res=0x40, C=1. SHL on 0x81 -> res=0x02, C=1. SUB 0x00-0x01 -> res=0xFF, C=1 (borrow).
